// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed from a small word FIFO.
//
// Ports:
//   i_clock     system clock, all logic on the rising edge
//   i_reset     synchronous active-high reset
//   i_tick      one-cycle baud enable, OVERSAMPLE pulses per bit period
//   i_data_in   word to enqueue
//   i_tx_start  push strobe, one word per high cycle
//   o_bit_tx    registered serial line, idle high
//   o_tx_done   one-cycle pulse on the final tick of the last stop bit
//   o_full      FIFO holds FIFO_DEPTH words
//   o_empty     FIFO holds no words
//   o_busy      frame in progress (any state but IDLE)
//   o_overflow  one-cycle pulse after a push was dropped on a full FIFO
module uart_tx_fifo #(
  parameter int WIDTH_WORD_TX = 8,
  parameter int CANT_BIT_STOP = 1,
  parameter int PARITY_MODE   = 0,
  parameter int OVERSAMPLE    = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_tick,
  input  logic [WIDTH_WORD_TX-1:0] i_data_in,
  input  logic                     i_tx_start,
  output logic                     o_bit_tx,
  output logic                     o_tx_done,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_busy,
  output logic                     o_overflow
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(WIDTH_WORD_TX - 1);
  localparam logic [3:0]    STOP_LAST = 4'(CANT_BIT_STOP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                   state_q, state_d;
  logic [TW-1:0]            tick_cnt_q, tick_cnt_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic [WIDTH_WORD_TX-1:0] shift_q, shift_d;
  logic                     parity_q, parity_d;
  logic                     bit_tx_q, bit_tx_d;
  logic                     overflow_q, overflow_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [WIDTH_WORD_TX-1:0] mem_q [FIFO_DEPTH];

  logic full, empty, push, pop, tick_last, tx_done;

  // FIFO bookkeeping
  always_comb begin
    full       = (count_q == CW'(FIFO_DEPTH));
    empty      = (count_q == '0);
    push       = i_tx_start && !full;
    pop        = (state_q == S_IDLE) && !empty;
    overflow_d = i_tx_start && full;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame sequencer
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_done    = 1'b0;
    tick_last  = i_tick && (tick_cnt_q == TICK_LAST);

    if (state_q != S_IDLE && i_tick) begin
      tick_cnt_d = tick_last ? '0 : tick_cnt_q + TW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d    = mem_q[rd_ptr_q];
          parity_d   = (^mem_q[rd_ptr_q]) ^ (PARITY_MODE == 2);
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (tick_last) state_d = S_DATA;
      end
      S_DATA: begin
        if (tick_last) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick_last) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick_last) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            tx_done   = 1'b1;
            state_d   = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line value follows the next state so the register lines up with it.
    unique case (state_d)
      S_START:  bit_tx_d = 1'b0;
      S_DATA:   bit_tx_d = shift_d[0];
      S_PARITY: bit_tx_d = parity_d;
      default:  bit_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_tx_q   <= 1'b1;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_tx_q   <= bit_tx_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset && push) mem_q[wr_ptr_q] <= i_data_in;
  end

  // Done is taken straight from the final stop tick so the IDLE gap before a
  // back-to-back frame is exactly one cycle.
  assign o_tx_done  = tx_done && !i_reset;
  assign o_bit_tx   = bit_tx_q;
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_busy     = (state_q != S_IDLE);
  assign o_overflow = overflow_q;

endmodule
